// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words from the I-cache over a
// req/valid handshake and feeds the IF/ID register, with a one-entry skid buffer.
module fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 16'h0000,
    parameter logic [WORD_SIZE-1:0] NOP_INST  = 16'hB000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 i_mem_req,
    output logic [WORD_SIZE-1:0] i_mem_addr,
    input  logic                 i_mem_valid,
    input  logic [WORD_SIZE-1:0] i_mem_data,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    output logic [WORD_SIZE-1:0] if_id_inst,
    output logic [WORD_SIZE-1:0] if_id_seq_pc,
    output logic                 if_id_valid
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] SQUASH = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] redir_pc_q, redir_pc_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [WORD_SIZE-1:0] skid_inst_q, skid_inst_d;
    logic [WORD_SIZE-1:0] skid_seq_pc_q, skid_seq_pc_d;
    logic [WORD_SIZE-1:0] inst_q, inst_d;
    logic [WORD_SIZE-1:0] seq_pc_q, seq_pc_d;
    logic                 valid_q, valid_d;
    logic [WORD_SIZE-1:0] pc_inc;

    assign pc_inc       = pc_q + 1'b1;
    assign i_mem_req    = (state_q == REQ) || (state_q == SQUASH);
    assign i_mem_addr   = pc_q;
    assign if_id_inst   = inst_q;
    assign if_id_seq_pc = seq_pc_q;
    assign if_id_valid  = valid_q;

    // IF/ID defaults to a bubble; a redirect outranks a stall, which outranks a load.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redir_pc_d    = redir_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_inst_d   = skid_inst_q;
        skid_seq_pc_d = skid_seq_pc_q;
        inst_d        = NOP_INST;
        seq_pc_d      = seq_pc_q;
        valid_d       = 1'b0;

        if (state_q != HALTED) begin
            if (redirect_valid) begin
                skid_valid_d = 1'b0;
            end else if (stall) begin
                inst_d  = inst_q;
                valid_d = valid_q;
            end

            case (state_q)
                IDLE: begin
                    if (skid_valid_q && !stall && !redirect_valid) begin
                        inst_d       = skid_inst_q;
                        seq_pc_d     = skid_seq_pc_q;
                        valid_d      = 1'b1;
                        skid_valid_d = 1'b0;
                    end
                    if (halt) begin
                        state_d = HALTED;
                    end else if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        state_d = REQ;
                    end else if (!skid_valid_q) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (i_mem_valid) begin
                        if (redirect_valid) begin
                            pc_d    = redirect_pc;
                            state_d = halt ? IDLE : REQ;
                        end else if (!stall) begin
                            inst_d   = i_mem_data;
                            seq_pc_d = pc_inc;
                            valid_d  = 1'b1;
                            pc_d     = pc_inc;
                            state_d  = halt ? IDLE : REQ;
                        end else begin
                            skid_valid_d  = 1'b1;
                            skid_inst_d   = i_mem_data;
                            skid_seq_pc_d = pc_inc;
                            pc_d          = pc_inc;
                            state_d       = IDLE;
                        end
                    end else if (redirect_valid) begin
                        redir_pc_d = redirect_pc;
                        state_d    = SQUASH;
                    end
                end
                SQUASH: begin
                    // The outstanding word belongs to the old path and is discarded.
                    if (redirect_valid) begin
                        redir_pc_d = redirect_pc;
                    end
                    if (i_mem_valid) begin
                        pc_d    = redirect_valid ? redirect_pc : redir_pc_q;
                        state_d = halt ? IDLE : REQ;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            redir_pc_q    <= '0;
            skid_valid_q  <= 1'b0;
            skid_inst_q   <= NOP_INST;
            skid_seq_pc_q <= '0;
            inst_q        <= NOP_INST;
            seq_pc_q      <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_pc_q    <= redir_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_inst_q   <= skid_inst_d;
            skid_seq_pc_q <= skid_seq_pc_d;
            inst_q        <= inst_d;
            seq_pc_q      <= seq_pc_d;
            valid_q       <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue holds the instruction words
// the cache model hands out, and each IF/ID load is popped and checked.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'hB000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_mem_req;
    logic [15:0] i_mem_addr;
    logic        i_mem_valid;
    logic [15:0] i_mem_data;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_seq_pc;
    logic        if_id_valid;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] expQ[$];
    logic [15:0] lastInst = 16'h0;
    logic [15:0] lastSeq  = 16'h0;

    fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_mem_req     (i_mem_req),
        .i_mem_addr    (i_mem_addr),
        .i_mem_valid   (i_mem_valid),
        .i_mem_data    (i_mem_data),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .if_id_inst    (if_id_inst),
        .if_id_seq_pc  (if_id_seq_pc),
        .if_id_valid   (if_id_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expectReq(input logic [15:0] addr);
        checkOutput("req_high", 32'(i_mem_req), 32'd1);
        checkOutput("req_addr", 32'(i_mem_addr), 32'(addr));
    endtask

    task automatic expectNoReq();
        checkOutput("req_low", 32'(i_mem_req), 32'd0);
    endtask

    // Cache model answers addr with 16'h1000+addr; keep=1 means the word must reach IF/ID.
    task automatic respond(input logic [15:0] addr, input bit keep);
        logic [15:0] data;
        logic [15:0] seq;
        data        = 16'h1000 + addr;
        seq         = addr + 16'd1;
        i_mem_valid = 1'b1;
        i_mem_data  = data;
        if (keep) expQ.push_back({data, seq});
    endtask

    // mode 0: bubble expected, 1: next scoreboard entry loaded, 2: IF/ID held.
    task automatic applyStimulus(input int mode);
        logic [31:0] e;
        @(posedge clk);
        #1;
        i_mem_valid    = 1'b0;
        i_mem_data     = 16'h0;
        redirect_valid = 1'b0;
        checkOutput("ifid_valid", 32'(if_id_valid), (mode == 0) ? 32'd0 : 32'd1);
        if (mode == 0) begin
            checkOutput("bubble_inst", 32'(if_id_inst), 32'(NOP));
        end else begin
            if (mode == 1) begin
                if (expQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $error("[TB] FAIL scoreboard_empty observed=load expected=none");
                end else begin
                    e        = expQ.pop_front();
                    lastInst = e[31:16];
                    lastSeq  = e[15:0];
                end
            end
            checkOutput("ifid_inst", 32'(if_id_inst), 32'(lastInst));
            checkOutput("ifid_seq_pc", 32'(if_id_seq_pc), 32'(lastSeq));
        end
    endtask

    task automatic doRedirect(input logic [15:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
    endtask

    initial begin
        reset_n        = 1'b0;
        i_mem_valid    = 1'b0;
        i_mem_data     = 16'h0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        halt           = 1'b0;

        @(posedge clk);
        #1;
        checkOutput("rst_req", 32'(i_mem_req), 32'd0);
        checkOutput("rst_addr", 32'(i_mem_addr), 32'h0);
        checkOutput("rst_inst", 32'(if_id_inst), 32'(NOP));
        checkOutput("rst_seq", 32'(if_id_seq_pc), 32'h0);
        checkOutput("rst_valid", 32'(if_id_valid), 32'd0);
        reset_n = 1'b1;
        expectNoReq();
        applyStimulus(0);

        // Zero-wait cache streaming
        expectReq(16'd0); respond(16'd0, 1'b1); applyStimulus(1);
        expectReq(16'd1); respond(16'd1, 1'b1); applyStimulus(1);
        expectReq(16'd2); respond(16'd2, 1'b1); applyStimulus(1);

        // Stall as word 3 returns: skid holds it, IF/ID holds 1002
        expectReq(16'd3); stall = 1'b1; respond(16'd3, 1'b1); applyStimulus(2);
        expectNoReq(); applyStimulus(2);
        expectNoReq(); stall = 1'b0; applyStimulus(1);
        expectNoReq(); applyStimulus(0);
        expectReq(16'd4); respond(16'd4, 1'b1); applyStimulus(1);

        // Four-cycle miss at address 5
        for (int i = 0; i < 3; i++) begin
            expectReq(16'd5); applyStimulus(0);
        end
        expectReq(16'd5); respond(16'd5, 1'b1); applyStimulus(1);
        expectReq(16'd6); respond(16'd6, 1'b1); applyStimulus(1);

        // Redirect during miss at 7, overwritten by a second redirect
        expectReq(16'd7); doRedirect(16'h0030); applyStimulus(0);
        expectReq(16'd7); doRedirect(16'h0040); applyStimulus(0);
        expectReq(16'd7); respond(16'd7, 1'b0); applyStimulus(0);
        expectReq(16'h0040); respond(16'h0040, 1'b1); applyStimulus(1);

        // Redirect coincident with valid and stall: word dropped, bubble
        expectReq(16'h0041); stall = 1'b1; doRedirect(16'hFFFF); respond(16'h0041, 1'b0);
        applyStimulus(0);
        stall = 1'b0;
        expectReq(16'hFFFF); respond(16'hFFFF, 1'b1); applyStimulus(1);

        // Skid full with stall, then redirect: skid discarded
        expectReq(16'h0000); stall = 1'b1; respond(16'h0000, 1'b0); applyStimulus(2);
        expectNoReq(); doRedirect(16'h0020); applyStimulus(0);
        stall = 1'b0;
        expectReq(16'h0020); respond(16'h0020, 1'b1); applyStimulus(1);

        // Halt during a miss: word still delivered, then halted for good
        expectReq(16'h0021); halt = 1'b1; applyStimulus(0);
        expectReq(16'h0021); respond(16'h0021, 1'b1); applyStimulus(1);
        expectNoReq(); applyStimulus(0);
        halt = 1'b0;
        expectNoReq(); doRedirect(16'h0010); applyStimulus(0);
        expectNoReq(); applyStimulus(0);
        expectNoReq(); applyStimulus(0);

        // Reset exits HALTED; then a reset mid-miss restarts at RESET_PC
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        expectNoReq(); applyStimulus(0);
        expectReq(16'd0); respond(16'd0, 1'b1); applyStimulus(1);
        expectReq(16'd1); respond(16'd1, 1'b1); applyStimulus(1);
        expectReq(16'd2); applyStimulus(0);
        reset_n = 1'b0;
        #1;
        checkOutput("midmiss_req", 32'(i_mem_req), 32'd0);
        checkOutput("midmiss_addr", 32'(i_mem_addr), 32'h0);
        checkOutput("midmiss_valid", 32'(if_id_valid), 32'd0);
        reset_n = 1'b1;
        applyStimulus(0);
        expectReq(16'd0); respond(16'd0, 1'b1); applyStimulus(1);

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined TSC CPU: owns the PC, requests instruction words from the instruction cache over a request/valid handshake, and delivers them through the IF/ID pipeline register to the instruction decoder. Handles variable cache latency, ID-stage stalls via a one-entry skid buffer, branch/jump redirects (including redirects that arrive while a miss is outstanding), and halt.

## Interface
- `WORD_SIZE`, 16, instruction/address width
- `RESET_PC`, 16'h0000, first fetch address after reset
- `NOP_INST`, 16'hB000, bubble encoding (opcode 11: decodes to no instruction type, no RegWrite/MemRead/MemWrite)

- `clk` in 1, single clock, all state on rising edge
- `reset_n` in 1, asynchronous, active-low reset
- `i_mem_req` out 1, fetch request outstanding
- `i_mem_addr` out 16, word address of request; stable while `i_mem_req`=1
- `i_mem_valid` in 1, one-cycle pulse: `i_mem_data` answers current request
- `i_mem_data` in 16, instruction word
- `stall` in 1, hazard unit: hold IF/ID
- `redirect_valid` in 1, taken branch/jump/JPR/JRL
- `redirect_pc` in 16, new fetch target
- `halt` in 1, HLT decoded in ID
- `if_id_inst` out 16, instruction to decoder
- `if_id_seq_pc` out 16, fetched address + 1 (link/branch base)
- `if_id_valid` out 1, IF/ID holds a real instruction

## Operation
- State: `pc`, `redir_pc`, skid buffer {`skid_valid`, `skid_inst`, `skid_seq_pc`}, FSM IDLE / REQ / SQUASH / HALTED.
- `i_mem_req` = (state==REQ || state==SQUASH); `i_mem_addr` = `pc`.
- IDLE: halt -> HALTED; else skid_valid=0 -> REQ; else stay. If skid_valid and stall=0 and no redirect: IF/ID <= skid, skid_valid <= 0.
- REQ, i_mem_valid=1:
  - redirect: drop word, pc <= redirect_pc, -> REQ (IDLE if halt).
  - stall=0: IF/ID <= {data, pc+1, valid=1}, pc <= pc+1, -> REQ (IDLE if halt).
  - stall=1: skid <= {data, pc+1}, pc <= pc+1, -> IDLE.
- REQ, i_mem_valid=0: redirect -> redir_pc <= redirect_pc, -> SQUASH; otherwise stay (address held).
- SQUASH: i_mem_valid=1 -> drop word, pc <= redir_pc, -> REQ (IDLE if halt). Further redirects overwrite redir_pc.
- HALTED: terminal; all inputs ignored; exit only by reset.
- IF/ID priority: redirect (bubble: inst=NOP_INST, valid=0, seq_pc unchanged; skid cleared) > stall (hold) > load > bubble when nothing loads.
- Arithmetic: pc+1 is modulo 2^16 (16'hFFFF -> 16'h0000).
- Halt while request outstanding: request completes normally (word to IF/ID or skid), then IDLE -> HALTED.

## Timing
- Reset (async): pc=RESET_PC, state IDLE, i_mem_req=0, i_mem_addr=RESET_PC, if_id_inst=NOP_INST, if_id_seq_pc=0, if_id_valid=0, skid_valid=0, redir_pc=0.
- First request in the first cycle after the first rising edge following reset release.
- i_mem_valid may arrive in any cycle with i_mem_req=1, including the first; zero-wait cache sustains 1 instruction/cycle.
- Fetch-to-IF/ID latency: word visible on IF/ID outputs the cycle after i_mem_valid.
- Redirect: next request (redirect_pc) issued the cycle after redirect if idle/completing; after squashed word returns otherwise.
- Skid unload to new request: one bubble cycle (IDLE) before the next request.
- reset_n low mid-miss: abandon request immediately; cache is reset with the CPU.

## Test plan
- Reset, RESET_PC=0, zero-wait cache returning 16'h1000+addr: requests 0,1,2 consecutive cycles; IF/ID shows 1000/seq 1, 1001/seq 2, 1002/seq 3, valid=1 each cycle.
- 4-cycle miss at addr 5: addr 5 held for 4 cycles with req=1, if_id_valid=0 bubbles, then inst 1005/seq 6.
- stall=1 as word for addr 3 returns: IF/ID holds 1002, req=0; stall drops -> IF/ID=1003/seq 4, request addr 4 one cycle later.
- redirect to 16'h0040 during miss at addr 7: addr stays 7 until valid, word dropped, if_id_valid=0, next request 16'h0040, IF/ID later 1040/seq 41.
- redirect coincident with i_mem_valid and stall=1 with skid full: word dropped, skid cleared, IF/ID bubble, next request redirect_pc; pc=16'hFFFF fetch gives seq_pc=0.
- halt during outstanding miss: word delivered, state HALTED, req=0 thereafter despite redirects; reset_n pulse mid-miss restarts at RESET_PC.
